// File: rtl/conv_row_scheduler.sv
// Sequences one convolution pass: streams BRAM1 rows into a 3-row window,
// hands each window to the engine, and stores every result row in BRAM2.
module conv_row_scheduler #(
    parameter int DATA_W   = 1024,
    parameter int ADDR_W   = 8,
    parameter int NUM_ROWS = 128,
    parameter int TIMEOUT  = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              bram1_en,
    output logic [ADDR_W-1:0] bram1_addr,
    input  logic [DATA_W-1:0] bram1_dout,
    output logic [DATA_W-1:0] win_row0,
    output logic [DATA_W-1:0] win_row1,
    output logic [DATA_W-1:0] win_row2,
    output logic              eng_start,
    input  logic              eng_valid,
    input  logic [DATA_W-1:0] eng_result,
    output logic              bram2_wen,
    output logic [ADDR_W-1:0] bram2_addr,
    output logic [DATA_W-1:0] bram2_din
);

    localparam int                WAIT_W    = $clog2(TIMEOUT + 1);
    localparam logic [ADDR_W-1:0] LAST_ROW  = ADDR_W'(NUM_ROWS - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_FILL_DRAIN,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_FETCH,
        S_FETCH_CAP
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          fill_cnt_q, fill_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic [ADDR_W-1:0]   r_q, r_d;
    logic [ADDR_W-1:0]   in_ptr_q, in_ptr_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   win_row0_q, win_row0_d;
    logic [DATA_W-1:0]   win_row1_q, win_row1_d;
    logic [DATA_W-1:0]   win_row2_q, win_row2_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                bram1_en_q, bram1_en_d;
    logic [ADDR_W-1:0]   bram1_addr_q, bram1_addr_d;
    logic                eng_start_q, eng_start_d;
    logic                bram2_wen_q, bram2_wen_d;
    logic [ADDR_W-1:0]   bram2_addr_q, bram2_addr_d;
    logic [DATA_W-1:0]   bram2_din_q, bram2_din_d;

    // Outputs are decoded from the next state so every one of them is a flop.
    always_comb begin
        // NOTE: every signal gets a default first so no path through the case infers a latch.
        state_d      = state_q;
        fill_cnt_d   = fill_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        r_d          = r_q;
        in_ptr_d     = in_ptr_q;
        win_row0_d   = win_row0_q;
        win_row1_d   = win_row1_q;
        win_row2_d   = win_row2_q;
        err_d        = err_q;
        bram1_addr_d = bram1_addr_q;
        bram2_addr_d = bram2_addr_q;
        bram2_din_d  = bram2_din_q;
        bram1_en_d   = 1'b0;
        bram2_wen_d  = 1'b0;
        eng_start_d  = 1'b0;
        done_d       = 1'b0;

        // BRAM1 data lands one cycle after the read, so capture follows bram1_en_q.
        rd_valid_d = bram1_en_q;
        if (rd_valid_q) begin
            win_row0_d = win_row1_q;
            win_row1_d = win_row2_q;
            win_row2_d = bram1_dout;
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_FILL;
                    err_d        = 1'b0;
                    r_d          = '0;
                    fill_cnt_d   = '0;
                    bram1_en_d   = 1'b1;
                    bram1_addr_d = '0;
                    in_ptr_d     = ADDR_W'(1);
                end
            end
            S_FILL: begin
                if (fill_cnt_q < 2'd2) begin
                    fill_cnt_d   = fill_cnt_q + 2'd1;
                    bram1_en_d   = 1'b1;
                    bram1_addr_d = in_ptr_q;
                    in_ptr_d     = in_ptr_q + ADDR_W'(1);
                end else begin
                    state_d = S_FILL_DRAIN;
                end
            end
            S_FILL_DRAIN: begin
                state_d     = S_ISSUE;
                eng_start_d = 1'b1;
            end
            S_ISSUE: begin
                state_d    = S_WAIT;
                wait_cnt_d = '0;
            end
            S_WAIT: begin
                if (eng_valid) begin
                    state_d      = S_WRITE;
                    bram2_din_d  = eng_result;
                    bram2_wen_d  = 1'b1;
                    bram2_addr_d = r_q;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                end
            end
            S_WRITE: begin
                if (r_q == LAST_ROW) begin
                    state_d = S_IDLE;
                    done_d  = 1'b1;
                end else begin
                    state_d      = S_FETCH;
                    r_d          = r_q + ADDR_W'(1);
                    bram1_en_d   = 1'b1;
                    bram1_addr_d = in_ptr_q;
                    in_ptr_d     = in_ptr_q + ADDR_W'(1);
                end
            end
            S_FETCH: begin
                state_d = S_FETCH_CAP;
            end
            S_FETCH_CAP: begin
                state_d     = S_ISSUE;
                eng_start_d = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            fill_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            r_q          <= '0;
            in_ptr_q     <= '0;
            rd_valid_q   <= 1'b0;
            // NOTE: the window rows are reset too, so an aborted pass leaves no stale image data behind.
            win_row0_q   <= '0;
            win_row1_q   <= '0;
            win_row2_q   <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            bram1_en_q   <= 1'b0;
            bram1_addr_q <= '0;
            eng_start_q  <= 1'b0;
            bram2_wen_q  <= 1'b0;
            bram2_addr_q <= '0;
            bram2_din_q  <= '0;
        end else begin
            state_q      <= state_d;
            fill_cnt_q   <= fill_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            r_q          <= r_d;
            in_ptr_q     <= in_ptr_d;
            rd_valid_q   <= rd_valid_d;
            win_row0_q   <= win_row0_d;
            win_row1_q   <= win_row1_d;
            win_row2_q   <= win_row2_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_q        <= err_d;
            bram1_en_q   <= bram1_en_d;
            bram1_addr_q <= bram1_addr_d;
            eng_start_q  <= eng_start_d;
            bram2_wen_q  <= bram2_wen_d;
            bram2_addr_q <= bram2_addr_d;
            bram2_din_q  <= bram2_din_d;
        end
    end

    assign busy       = busy_q;
    assign done       = done_q;
    assign err        = err_q;
    assign bram1_en   = bram1_en_q;
    assign bram1_addr = bram1_addr_q;
    assign win_row0   = win_row0_q;
    assign win_row1   = win_row1_q;
    assign win_row2   = win_row2_q;
    assign eng_start  = eng_start_q;
    assign bram2_wen  = bram2_wen_q;
    assign bram2_addr = bram2_addr_q;
    assign bram2_din  = bram2_din_q;

endmodule

// File: tb/tb_conv_row_scheduler.sv
// Bench for conv_row_scheduler: BRAM1 and engine models plus a cycle-level
// reference of the expected write/read schedule derived from latencies.
module tb_conv_row_scheduler;

    localparam int DATA_W   = 1024;
    localparam int ADDR_W   = 8;
    localparam int NUM_ROWS = 128;
    localparam int TIMEOUT  = 255;
    localparam int IMG_ROWS = NUM_ROWS + 2;
    localparam int BOUND    = 4000;

    logic              clk;
    logic              rst;
    logic              start;
    logic              busy;
    logic              done;
    logic              err;
    logic              bram1_en;
    logic [ADDR_W-1:0] bram1_addr;
    logic [DATA_W-1:0] bram1_dout;
    logic [DATA_W-1:0] win_row0;
    logic [DATA_W-1:0] win_row1;
    logic [DATA_W-1:0] win_row2;
    logic              eng_start;
    logic              eng_valid;
    logic [DATA_W-1:0] eng_result;
    logic              bram2_wen;
    logic [ADDR_W-1:0] bram2_addr;
    logic [DATA_W-1:0] bram2_din;

    conv_row_scheduler #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .NUM_ROWS(NUM_ROWS), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
        .bram1_en(bram1_en), .bram1_addr(bram1_addr), .bram1_dout(bram1_dout),
        .win_row0(win_row0), .win_row1(win_row1), .win_row2(win_row2),
        .eng_start(eng_start), .eng_valid(eng_valid), .eng_result(eng_result),
        .bram2_wen(bram2_wen), .bram2_addr(bram2_addr), .bram2_din(bram2_din)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int unsigned       cyc;
        int                addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    // Stimulus configuration (written by the main sequence)
    logic [DATA_W-1:0] mem [IMG_ROWS];
    int                lat [NUM_ROWS];
    bit                eng_silent;
    bit                rot;
    bit                spurious;

    // Observations (written only by the model process)
    wr_t         wr_q[$];
    int unsigned rd_cyc_q[$];
    int          rd_addr_q[$];
    int unsigned es_cyc_q[$];
    int unsigned done_cyc_q[$];
    int unsigned err_rise_q[$];
    int unsigned t0;

    // Reference schedule
    int unsigned exp_wen[NUM_ROWS];
    int unsigned exp_rd[IMG_ROWS];
    int unsigned exp_done;

    int checks   = 0;
    int failures = 0;

    function automatic logic [DATA_W-1:0] eng_fn(input logic [DATA_W-1:0] a, b, c, input bit rt);
        if (rt) return a ^ {b[DATA_W-2:0], b[DATA_W-1]} ^ {c[DATA_W-3:0], c[DATA_W-1:DATA_W-2]};
        return a ^ b ^ c;
    endfunction

    // BRAM1 read model, engine model and output monitor, all sampled mid-cycle.
    initial begin
        logic [DATA_W-1:0] dout_next;
        logic [DATA_W-1:0] res_pend;
        bit                rd_pend;
        bit                err_prev;
        int                cnt;
        int                issue_idx;
        dout_next = '0; res_pend = '0; rd_pend = 0; err_prev = 0;
        cnt = 0; issue_idx = 0; t0 = 0;
        bram1_dout = '0; eng_valid = 1'b0; eng_result = '0;
        forever begin
            @(negedge clk);
            if (start && !busy) begin
                wr_q.delete(); rd_cyc_q.delete(); rd_addr_q.delete();
                es_cyc_q.delete(); done_cyc_q.delete(); err_rise_q.delete();
                t0 = cyc;
            end
            if (rd_pend) bram1_dout = dout_next;
            rd_pend = bram1_en;
            if (bram1_en) dout_next = (int'(bram1_addr) < IMG_ROWS) ? mem[bram1_addr] : '0;
            if (!busy) issue_idx = 0;
            eng_valid = 1'b0;
            if (cnt > 0) begin
                cnt--;
                if (cnt == 0) begin
                    eng_valid  = 1'b1;
                    eng_result = res_pend;
                end
            end
            if (eng_start) begin
                if (!eng_silent) begin
                    cnt      = lat[issue_idx % NUM_ROWS];
                    res_pend = eng_fn(win_row0, win_row1, win_row2, rot);
                end
                issue_idx++;
            end
            if (spurious && !eng_valid && cnt == 0 && (!busy || bram1_en)) begin
                eng_valid  = 1'b1;
                eng_result = {(DATA_W/32){$urandom}};
            end
            if (bram2_wen) wr_q.push_back('{cyc, int'(bram2_addr), bram2_din});
            if (bram1_en) begin
                rd_cyc_q.push_back(cyc);
                rd_addr_q.push_back(int'(bram1_addr));
            end
            if (eng_start) es_cyc_q.push_back(cyc);
            if (done) done_cyc_q.push_back(cyc);
            if (err && !err_prev) err_rise_q.push_back(cyc);
            err_prev = err;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_row(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed[63:0] %0h expected[63:0] %0h", tag, obs[63:0], exp[63:0]);
        end
    endtask

    task automatic check_all_zero(input string p);
        check({p, "_busy"}, busy, 0);
        check({p, "_done"}, done, 0);
        check({p, "_err"}, err, 0);
        check({p, "_b1en"}, bram1_en, 0);
        check({p, "_b1addr"}, bram1_addr, 0);
        check({p, "_estart"}, eng_start, 0);
        check({p, "_wen"}, bram2_wen, 0);
        check({p, "_b2addr"}, bram2_addr, 0);
        check_row({p, "_din"}, bram2_din, '0);
        check_row({p, "_win0"}, win_row0, '0);
        check_row({p, "_win1"}, win_row1, '0);
        check_row({p, "_win2"}, win_row2, '0);
    endtask

    task automatic fill_pattern();
        for (int k = 0; k < IMG_ROWS; k++) begin
            logic [7:0] kb;
            kb     = 8'(k);
            mem[k] = {(DATA_W/8){kb}};
        end
    endtask

    task automatic fill_random();
        for (int k = 0; k < IMG_ROWS; k++)
            for (int j = 0; j < DATA_W/32; j++) mem[k][j*32 +: 32] = $urandom;
    endtask

    task automatic set_lat(input bit random_lat);
        for (int i = 0; i < NUM_ROWS; i++) lat[i] = random_lat ? int'($urandom_range(7, 1)) : 1;
    endtask

    // Schedule from the timing rules: first issue at 5, row period 4+L,
    // write 1+L after issue, three fill reads at 1..3, one fetch after each write.
    task automatic compute_model();
        int unsigned issue;
        issue = 5;
        for (int i = 0; i < NUM_ROWS; i++) begin
            exp_wen[i] = issue + 1 + lat[i];
            issue      = issue + 4 + lat[i];
        end
        for (int k = 0; k < IMG_ROWS; k++)
            exp_rd[k] = (k < 3) ? k + 1 : exp_wen[k-3] + 1;
        exp_done = exp_wen[NUM_ROWS-1] + 1;
    endtask

    task automatic do_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_rel(input int unsigned n);
        while (cyc + 1 < t0 + n) @(negedge clk);
        @(posedge clk); #1;
    endtask

    task automatic wait_end(input string tag);
        int n;
        n = 0;
        while (done_cyc_q.size() == 0 && err_rise_q.size() == 0 && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_finished_in_bound"}, n < BOUND, 1);
        repeat (10) @(negedge clk);
    endtask

    task automatic verify_pass(input string p);
        compute_model();
        check({p, "_wen_count"}, wr_q.size(), NUM_ROWS);
        for (int i = 0; i < NUM_ROWS && i < wr_q.size(); i++) begin
            check($sformatf("%s_wen_addr[%0d]", p, i), wr_q[i].addr, i);
            check($sformatf("%s_wen_cyc[%0d]", p, i), wr_q[i].cyc - t0, exp_wen[i]);
            check_row($sformatf("%s_wen_data[%0d]", p, i), wr_q[i].data,
                      eng_fn(mem[i], mem[i+1], mem[i+2], rot));
        end
        check({p, "_rd_count"}, rd_addr_q.size(), IMG_ROWS);
        for (int k = 0; k < IMG_ROWS && k < rd_addr_q.size(); k++) begin
            check($sformatf("%s_rd_addr[%0d]", p, k), rd_addr_q[k], k);
            check($sformatf("%s_rd_cyc[%0d]", p, k), rd_cyc_q[k] - t0, exp_rd[k]);
        end
        check({p, "_estart_count"}, es_cyc_q.size(), NUM_ROWS);
        if (es_cyc_q.size() > 0) check({p, "_estart_first"}, es_cyc_q[0] - t0, 5);
        check({p, "_done_count"}, done_cyc_q.size(), 1);
        if (done_cyc_q.size() > 0) check({p, "_done_cyc"}, done_cyc_q[0] - t0, exp_done);
        check({p, "_err_rise"}, err_rise_q.size(), 0);
        check({p, "_busy_after"}, busy, 0);
    endtask

    initial begin
        int exp_partial;
        rst = 1'b1; start = 1'b0;
        eng_silent = 0; rot = 0; spurious = 0;
        fill_pattern();
        set_lat(0);

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        @(posedge clk); #1 rst = 1'b0;
        repeat (2) @(posedge clk); #1;

        // Test-plan pass: byte pattern image, XOR engine, L=1
        do_start();
        wait_end("p1");
        verify_pass("p1");

        // Random image, order-sensitive engine, random latency per row
        fill_random();
        set_lat(1);
        rot = 1;
        do_start();
        wait_end("p2");
        verify_pass("p2");

        // Engine never answers: timeout, then a clean pass clears err
        eng_silent = 1;
        do_start();
        wait_end("to");
        check("to_err_rise", err_rise_q.size(), 1);
        if (err_rise_q.size() > 0) check("to_err_cyc", err_rise_q[0] - t0, 6 + TIMEOUT);
        check("to_busy", busy, 0);
        check("to_wen_count", wr_q.size(), 0);
        check("to_done_count", done_cyc_q.size(), 0);
        check("to_estart_count", es_cyc_q.size(), 1);
        check("to_err_sticky", err, 1);
        eng_silent = 0;
        fill_random();
        do_start();
        @(negedge clk);
        check("restart_err_cleared", err, 0);
        check("restart_busy", busy, 1);
        wait_end("p3");
        verify_pass("p3");

        // Reset at cycle 300 aborts the pass
        set_lat(0);
        rot = 0;
        do_start();
        wait_rel(300);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check_all_zero("midrst");
        repeat (20) @(negedge clk);
        compute_model();
        exp_partial = 0;
        for (int i = 0; i < NUM_ROWS; i++) if (exp_wen[i] <= 300) exp_partial++;
        check("midrst_wen_count", wr_q.size(), exp_partial);
        check("midrst_done_count", done_cyc_q.size(), 0);
        check("midrst_busy", busy, 0);
        fill_random();
        do_start();
        wait_end("p4");
        verify_pass("p4");

        // start while busy and stray eng_valid in IDLE/FILL/FETCH are ignored
        spurious = 1;
        set_lat(1);
        do_start();
        wait_rel(100);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_rel(400);
        start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        wait_end("p5");
        verify_pass("p5");
        repeat (20) @(negedge clk);
        check("p5_no_restart_busy", busy, 0);
        check("p5_no_extra_wen", wr_q.size(), NUM_ROWS);
        check("p5_no_extra_done", done_cyc_q.size(), 1);
        spurious = 0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
